mac_pipe_block: RTL and testbench
=================================

Name: mac_pipe_block

Overview:
Parametrised, pipelined successor to the single/dual/quad MAC slice.
- LANES multiplier lanes share one B operand; lane products are packed by mode into one ACC_W result.
- Result is either emitted per beat (multiply-only) or accumulated over a programmable run length before one output.
- Valid/ready on input and output makes the block stallable inside systolic MAC arrays.

Parameters:
MIN_W, 8, lane operand width (unsigned)
LANES, 4, number of multiplier lanes; legal values 1, 2, 4
ACC_W, 32, accumulator/result width; must be >= LANES*MIN_W
CNT_W, 8, width of run-length counter and acc_len

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  LANES*MIN_W  lane operands; lane i = a[i*MIN_W +: MIN_W]
b  in  MIN_W  shared multiplicand
mode  in  2  00 single, 01 dual, 10 quad, 11 reserved
acc_en  in  1  1 = accumulate run, 0 = multiply-only
init_val  in  ACC_W  accumulator start value for a run
acc_len  in  CNT_W  beats per run; 0 treated as 1
out_valid  out  1  c holds a result
out_ready  in  1  downstream accepts c
c  out  ACC_W  result
input_fwd  out  LANES*MIN_W  registered copy of a, for chaining
ovf  out  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Clocking and reset: single clk domain; rst is synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, c=0, input_fwd=0, ovf=0; pipeline valids, run counter and in-run flag cleared.
- Beat acceptance: a beat is accepted on an edge where in_valid && in_ready. a, b, mode, acc_en, init_val and acc_len are all sampled with the beat.
- Pipeline:
  - S1 registers p_i = a_i*b (2*MIN_W unsigned) and the packed sum.
  - S2 is the accumulator/output register.
- Latency: multiply-only result appears on c with out_valid=1 two edges after acceptance.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, S1, S2, c, the counter and input_fwd all hold.
  - No beat is dropped or duplicated.
- Packing (all arithmetic is mod 2^ACC_W):
  - single: p0
  - dual: p0 + (p1<<MIN_W)
  - quad: sum over i=0..3 of p_i<<(i*MIN_W)
  - Reserved mode 11, or any mode needing more lanes than LANES, yields 0.
- acc_en=0: every accepted beat produces one output with c = packed sum. Any open run is aborted (partial sum and count discarded).
- acc_en=1 run state machine, IDLE -> RUN:
  - First beat (IDLE): acc = init_val + sum; len latched (0->1); cnt = 1.
  - Following beats (RUN): acc += sum; cnt++.
  - When cnt == len: out_valid=1, c = acc, then back to IDLE. The next beat reloads init_val.
  - acc_len=1: every beat outputs init_val + sum.
  - Intermediate beats produce no out_valid.
  - init_val and acc_len are ignored on non-first beats.
- out_valid: clears on an edge with out_ready=1 unless a new result lands on the same edge. Back-to-back results give continuous out_valid at full throughput.
- input_fwd: updates to a on each accepted beat, 1-cycle latency; holds otherwise.
- rst mid-run: in-flight beats discarded; the next beat starts a fresh run.

Optional Feature:
MAC_PIPE_SAT_EN
- Defined: accumulation saturates at 2^ACC_W-1 instead of wrapping. ovf sets on any clamp and stays set until rst.
- Undefined: wrap mod 2^ACC_W; ovf tied 0.
- Multiply-only path is identical in both builds.

Test Plan:
- Single mode, acc_en=0, a0=5, b=7, out_ready=1 -> c=35, out_valid 2 edges after acceptance for exactly 1 cycle.
- Quad mode, MIN_W=8, lanes 3..0 = 4,3,2,1, b=2 -> c=0x08060402; mode=11 -> c=0; LANES=2 build with quad -> c=0.
- acc_en=1, single, init_val=100, acc_len=3, beats a0=1,2,3 with b=10 -> one out_valid with c=160. Next run with init_val=0, acc_len=1, a0=4, b=4 -> c=16.
- out_ready low 3 cycles while out_valid=1 with beats offered -> in_ready=0, c held; after release every beat is output in order, none lost.
- rst asserted after 2 of 3 run beats -> out_valid=0, ovf=0. Next run init_val=0, acc_len=1, a0=1, b=1 -> c=1.
- ACC_W=16, init_val=0xFFF0, acc_len=1, sum=0x20 -> with MAC_PIPE_SAT_EN: c=0xFFFF, ovf=1. Without: c=0x0010, ovf=0.

Source files
------------

// File: rtl/mac_pipe_block.sv
`default_nettype none
// ============================================================================
//  Module   : mac_pipe_block
//  Purpose  : Pipelined multi-lane MAC slice. LANES unsigned multipliers share
//             one B operand, and their products are packed by mode into one
//             ACC_W result. The result is either emitted once per beat
//             (multiply-only) or accumulated over a programmable run length.
//             Valid/ready handshakes on both sides make the block stallable.
//  Options  : MAC_PIPE_SAT_EN - the accumulate path saturates at 2^ACC_W-1
//             and raises the sticky ovf flag. When it is undefined, the
//             accumulator wraps and ovf is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_pipe_block #(
  parameter int MIN_W = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*MIN_W-1:0] a_i,
  input  logic [MIN_W-1:0]       b_i,
  input  logic [1:0]             mode_i,
  input  logic                   acc_en_i,
  input  logic [ACC_W-1:0]       init_val_i,
  input  logic [CNT_W-1:0]       acc_len_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ACC_W-1:0]       c_o,
  output logic [LANES*MIN_W-1:0] input_fwd_o,
  output logic                   ovf_o
);

  // Wide enough that the shifted product of any lane fits before truncation.
  localparam int WIDE_W = ACC_W + 2*MIN_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Handshake
  logic stall;
  logic accept;

  // Stage 1 registers
  logic                   s1_valid_q;
  logic [ACC_W-1:0]       s1_sum_q;
  logic                   s1_acc_en_q;
  logic [ACC_W-1:0]       s1_init_q;
  logic [CNT_W-1:0]       s1_len_q;
  logic [LANES*MIN_W-1:0] fwd_q;

  // Stage 2 registers (accumulator, run control and output)
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic             out_valid_q, out_valid_d;

  // Datapath
  logic [2*MIN_W-1:0] prod [LANES];
  logic [WIDE_W-1:0]  sum_wide;
  logic [ACC_W-1:0]   packed_sum;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   len_eff;
  logic [CNT_W-1:0]   cnt_new;

  // A lane contributes only when the mode needs it and the build provides
  // enough lanes for that mode. Reserved or oversized modes pack to zero.
  function automatic logic lane_used(input logic [1:0] m, input int idx);
    case (m)
      2'b00:   lane_used = (idx == 0);
      2'b01:   lane_used = (LANES >= 2) && (idx < 2);
      2'b10:   lane_used = (LANES >= 4) && (idx < 4);
      default: lane_used = 1'b0;
    endcase
  endfunction

  // The whole pipeline freezes while a result waits for the downstream.
  assign stall      = out_valid_q && !out_ready_i;
  assign in_ready_o = !stall;
  assign accept     = in_valid_i && !stall;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign prod[gi] = (2*MIN_W)'(a_i[gi*MIN_W +: MIN_W]) * (2*MIN_W)'(b_i);
  end

  // Pack the lane products into one sum, with each lane offset by MIN_W bits.
  always_comb begin
    sum_wide = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_used(mode_i, i)) begin
        sum_wide = sum_wide + (WIDE_W'(prod[i]) << (i*MIN_W));
      end
    end
    packed_sum = sum_wide[ACC_W-1:0];
  end

  // Stage 1: capture the packed sum and the run controls of each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_acc_en_q <= 1'b0;
      s1_init_q   <= '0;
      s1_len_q    <= '0;
      fwd_q       <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid_i;
      if (accept) begin
        s1_sum_q    <= packed_sum;
        s1_acc_en_q <= acc_en_i;
        s1_init_q   <= init_val_i;
        s1_len_q    <= acc_len_i;
        fwd_q       <= a_i;
      end
    end
  end

  // The first beat of a run starts from init_val. Later beats build on acc.
  assign acc_base = (state_q == ST_IDLE) ? s1_init_q : acc_q;

`ifdef MAC_PIPE_SAT_EN
  logic [ACC_W:0] acc_wide;
  logic           acc_step;
  logic           ovf_q;

  assign acc_wide = {1'b0, acc_base} + {1'b0, s1_sum_q};
  assign acc_next = acc_wide[ACC_W] ? {ACC_W{1'b1}} : acc_wide[ACC_W-1:0];
  assign acc_step = !stall && s1_valid_q && s1_acc_en_q;

  // Sticky overflow: set by any clamp on an accumulating beat, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (acc_step && acc_wide[ACC_W]) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign acc_next = acc_base + s1_sum_q;
  assign ovf_o    = 1'b0;
`endif

  // Run control: decide the next accumulator, count and output for each beat.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    c_d         = c_q;
    out_valid_d = out_valid_q && !out_ready_i;
    if (state_q == ST_IDLE) begin
      len_eff = (s1_len_q == '0) ? CNT_W'(1) : s1_len_q;
      cnt_new = CNT_W'(1);
    end else begin
      len_eff = len_q;
      cnt_new = cnt_q + CNT_W'(1);
    end

    if (!stall && s1_valid_q) begin
      if (!s1_acc_en_q) begin
        // A multiply-only beat also aborts any open run.
        c_d         = s1_sum_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
        cnt_d       = '0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_new;
        len_d = len_eff;
        if (cnt_new == len_eff) begin
          c_d         = acc_next;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
    end
  end

  // Stage 2 state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign c_o         = c_q;
  assign input_fwd_o = fwd_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe_block.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_pipe_block
//  Purpose  : Directed self-checking bench for mac_pipe_block. It uses a
//             default 4-lane, 32-bit instance plus a 2-lane, 16-bit instance.
//             Expected values follow the MAC_PIPE_SAT_EN setting.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_pipe_block;

`ifdef MAC_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Main instance: MIN_W=8, LANES=4, ACC_W=32
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [7:0]  b = '0;
  logic [1:0]  mode = '0;
  logic        acc_en = 1'b0;
  logic [31:0] init_val = '0;
  logic [7:0]  acc_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] c;
  logic [31:0] input_fwd;
  logic        ovf;

  // Narrow instance: MIN_W=8, LANES=2, ACC_W=16
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [15:0] a2 = '0;
  logic [7:0]  b2 = '0;
  logic [1:0]  mode2 = '0;
  logic        acc_en2 = 1'b0;
  logic [15:0] init2 = '0;
  logic [7:0]  len2 = 8'd1;
  logic        out_valid2;
  logic [15:0] c2;
  logic [15:0] fwd2;
  logic        ovf2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_pipe_block #(.MIN_W(8), .LANES(4), .ACC_W(32), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .mode_i(mode), .acc_en_i(acc_en),
    .init_val_i(init_val), .acc_len_i(acc_len),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .c_o(c), .input_fwd_o(input_fwd), .ovf_o(ovf)
  );

  mac_pipe_block #(.MIN_W(8), .LANES(2), .ACC_W(16), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .a_i(a2), .b_i(b2), .mode_i(mode2), .acc_en_i(acc_en2),
    .init_val_i(init2), .acc_len_i(len2),
    .out_valid_o(out_valid2), .out_ready_i(1'b1),
    .c_o(c2), .input_fwd_o(fwd2), .ovf_o(ovf2)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sampling and driving both happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                           input logic te, input logic [31:0] ti, input logic [7:0] tl);
    int n;
    a = ta; b = tb; mode = tm; acc_en = te; init_val = ti; acc_len = tl;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq(tag, 64'(c), 64'(exp));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_c", 64'(c), 64'd0);
    check_eq("rst_fwd", 64'(input_fwd), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);

    // Single multiply, two-edge latency, one-cycle pulse: 5*7 = 35
    send_beat(32'h0000_0005, 8'd7, 2'b00, 1'b0, 32'd0, 8'd1);
    check_eq("lat_first_edge", 64'(out_valid), 64'd0);
    check_eq("fwd_after_beat", 64'(input_fwd), 64'h5);
    tick();
    check_eq("single_valid", 64'(out_valid), 64'd1);
    check_eq("single_c", 64'(c), 64'd35);
    tick();
    check_eq("single_pulse_once", 64'(out_valid), 64'd0);

    // Quad: lanes 4,3,2,1 times 2 give 0x08060402
    send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 8'd2, 2'b10, 1'b0, 32'd0, 8'd1);
    wait_out("quad", 32'h0806_0402);
    // Dual ignores the upper lanes: 4 + (6<<8)
    send_beat({8'd9, 8'd9, 8'd3, 8'd2}, 8'd2, 2'b01, 1'b0, 32'd0, 8'd1);
    wait_out("dual", 32'h0000_0604);
    // Quad 255*255 on every lane wraps mod 2^32
    send_beat(32'hFFFF_FFFF, 8'hFF, 2'b10, 1'b0, 32'd0, 8'd1);
    wait_out("quad_wrap", 32'hFFFF_FF01);
    // Reserved mode packs to zero
    send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 8'd2, 2'b11, 1'b0, 32'd0, 8'd1);
    wait_out("mode_rsvd", 32'd0);

    // Run of 3: 100 + 10 + 20 + 30; later beats carry junk init/len
    send_beat(32'd1, 8'd10, 2'b00, 1'b1, 32'd100, 8'd3);
    send_beat(32'd2, 8'd10, 2'b00, 1'b1, 32'd999, 8'd7);
    send_beat(32'd3, 8'd10, 2'b00, 1'b1, 32'd555, 8'd1);
    check_eq("run_no_mid_out", 64'(out_valid), 64'd0);
    wait_out("run3", 32'd160);
    send_beat(32'd4, 8'd4, 2'b00, 1'b1, 32'd0, 8'd1);
    wait_out("run1", 32'd16);
    // acc_len=0 behaves like 1: 5 + 2*3
    send_beat(32'd2, 8'd3, 2'b00, 1'b1, 32'd5, 8'd0);
    wait_out("run_len0", 32'd11);

    // A multiply-only beat aborts the open run, then a fresh run reloads init
    send_beat(32'd1, 8'd1, 2'b00, 1'b1, 32'd0, 8'd3);
    send_beat(32'd6, 8'd6, 2'b00, 1'b0, 32'd0, 8'd1);
    wait_out("abort_mul", 32'd36);
    send_beat(32'd1, 8'd1, 2'b00, 1'b1, 32'd10, 8'd2);
    send_beat(32'd1, 8'd1, 2'b00, 1'b1, 32'd500, 8'd9);
    wait_out("after_abort", 32'd12);

    // Back-pressure: 9 waits on c while 16 and 25 queue behind it
    out_ready = 1'b0;
    a = 32'd3; b = 8'd3; mode = 2'b00; acc_en = 1'b0; in_valid = 1'b1;
    tick();
    a = 32'd4; b = 8'd4;
    tick();
    check_eq("stall_first_valid", 64'(out_valid), 64'd1);
    a = 32'd5; b = 8'd5;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      check_eq("stall_c_hold", 64'(c), 64'd9);
      tick();
    end
    check_eq("stall_fwd_hold", 64'(input_fwd), 64'd4);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("drain_1_valid", 64'(out_valid), 64'd1);
    check_eq("drain_1_c", 64'(c), 64'd16);
    tick();
    check_eq("drain_2_valid", 64'(out_valid), 64'd1);
    check_eq("drain_2_c", 64'(c), 64'd25);
    tick();
    check_eq("drain_done", 64'(out_valid), 64'd0);

    // Accumulator overflow: 0xFFFFFFF0 + 0x20
    send_beat(32'd4, 8'd8, 2'b00, 1'b1, 32'hFFFF_FFF0, 8'd1);
    wait_out("acc_ovf", SAT ? 32'hFFFF_FFFF : 32'h0000_0010);
    check_eq("ovf_flag", 64'(ovf), 64'(SAT));

    // Reset in the middle of a run
    send_beat(32'd1, 8'd1, 2'b00, 1'b1, 32'd0, 8'd3);
    send_beat(32'd1, 8'd1, 2'b00, 1'b1, 32'd0, 8'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_ovf", 64'(ovf), 64'd0);
    check_eq("midrst_c", 64'(c), 64'd0);
    send_beat(32'd1, 8'd1, 2'b00, 1'b1, 32'd0, 8'd1);
    wait_out("post_rst_run", 32'd1);
    check_eq("post_rst_quiet", 64'(out_valid), 64'd0);

    // Narrow instance: dual works, quad needs more lanes than built
    a2 = {8'd3, 8'd2}; b2 = 8'd2; mode2 = 2'b01; acc_en2 = 1'b0; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    check_eq("n_dual_valid", 64'(out_valid2), 64'd1);
    check_eq("n_dual_c", 64'(c2), 64'h0604);
    mode2 = 2'b10; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    check_eq("n_quad_c", 64'(c2), 64'd0);
    // 16-bit overflow: 0xFFF0 + 0x20
    a2 = 16'd4; b2 = 8'd8; mode2 = 2'b00; acc_en2 = 1'b1; init2 = 16'hFFF0; len2 = 8'd1;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    check_eq("n_sat_valid", 64'(out_valid2), 64'd1);
    check_eq("n_sat_c", 64'(c2), SAT ? 64'hFFFF : 64'h0010);
    check_eq("n_sat_ovf", 64'(ovf2), 64'(SAT));
    check_eq("n_in_ready", 64'(in_ready2), 64'd1);
    check_eq("n_fwd", 64'(fwd2), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
